pixel_line_feeder: RTL and testbench

Upstream stage of imageProcessTop. It pulls 8-bit grayscale pixels from a raster-order source stream and drives them into the edge-detection core with line-level flow control. It primes the core's line buffers with PRIME_LINES lines, then releases exactly one line per core interrupt. After the last image line it injects PAD_LINES zero lines so the core flushes its final output rows.

---
 rtl/img_pkg.sv | 17 +
 rtl/intr_pending_tracker.sv | 31 +++
 rtl/pixel_line_feeder.sv | 93 +++++++++
 tb/tb_pixel_line_feeder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// img_pkg: constants shared across the image pipeline and the line feeder state encoding
//   IMG_LINE_WIDTH / IMG_NUM_LINES / IMG_DATA_W : default frame geometry, also sizes the core line buffers
//   feed_state_t                                : pixel_line_feeder FSM states
package img_pkg;
    localparam int IMG_LINE_WIDTH = 512;
    localparam int IMG_NUM_LINES  = 512;
    localparam int IMG_DATA_W     = 8;
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_WAIT,
        S_LINE,
        S_PAD,
        S_WAIT_PAD,
        S_DONE
    } feed_state_t;
endpackage

// File: rtl/intr_pending_tracker.sv
// intr_pending_tracker: rising-edge detect on the core interrupt, pending flag and sticky overrun
//   clk_i, rst_i : clock, synchronous active-high reset
//   intr_i       : interrupt level from the core
//   consume_i    : the feeder acts on the pending interrupt this cycle
//   pending_o    : an interrupt edge has not yet been consumed
//   overrun_o    : sticky; an edge arrived while one was already pending
module intr_pending_tracker (
    input  logic clk_i,
    input  logic rst_i,
    input  logic intr_i,
    input  logic consume_i,
    output logic pending_o,
    output logic overrun_o
);
    logic intr_q, pending_q, overrun_q, rise;
    assign rise      = intr_i && !intr_q;
    assign pending_o = pending_q;
    assign overrun_o = overrun_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            intr_q    <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            intr_q    <= intr_i;
            // a new edge wins over a same-cycle consume
            pending_q <= rise || (pending_q && !consume_i);
            overrun_q <= overrun_q || (rise && pending_q);
        end
    end
endmodule

// File: rtl/pixel_line_feeder.sv
// pixel_line_feeder: feeds raster pixels into the edge-detection core with line-level flow control
//   axi_clk, axi_reset       : clock, synchronous active-high reset
//   i_start                  : frame start pulse, honoured only when idle
//   s_valid, s_data, s_ready : source pixel stream
//   i_intr                   : core interrupt, one line buffer freed
//   o_data_valid, o_data     : registered pixel beat to the core
//   o_busy, o_done           : frame in progress / completion pulse
//   o_overrun                : sticky interrupt overrun
module pixel_line_feeder
    import img_pkg::*;
#(
    parameter int LINE_WIDTH  = IMG_LINE_WIDTH,
    parameter int NUM_LINES   = IMG_NUM_LINES,
    parameter int PRIME_LINES = 4,
    parameter int PAD_LINES   = 2,
    parameter int DATA_W      = IMG_DATA_W
) (
    input  logic              axi_clk,
    input  logic              axi_reset,
    input  logic              i_start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              i_intr,
    output logic              o_data_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun
);
    localparam int PW  = $clog2(LINE_WIDTH);
    localparam int LW  = $clog2(NUM_LINES + 1);
    localparam int PDW = $clog2(PAD_LINES + 1);
    feed_state_t state_q;
    logic [PW-1:0] pix_q, pix_d;
    logic [LW-1:0] line_q;
    logic [PDW-1:0] pad_q, pad_d;
    logic [DATA_W-1:0] data_q;
    logic valid_q, xfer, beat, last_pix, pending, consume;
    assign s_ready      = state_q == S_PRIME || state_q == S_LINE;
    assign xfer         = s_valid && s_ready;
    assign beat         = xfer || state_q == S_PAD;
    assign last_pix     = pix_q == PW'(LINE_WIDTH - 1);
    assign pix_d        = last_pix ? '0 : pix_q + 1'b1;
    assign pad_d        = pad_q + 1'b1;
    assign consume      = pending && (state_q == S_WAIT || state_q == S_WAIT_PAD);
    assign o_data_valid = valid_q;
    assign o_data       = data_q;
    assign o_done       = state_q == S_DONE;
    assign o_busy       = state_q != S_IDLE && state_q != S_DONE;
    intr_pending_tracker u_intr (
        .clk_i     (axi_clk),
        .rst_i     (axi_reset),
        .intr_i    (i_intr),
        .consume_i (consume),
        .pending_o (pending),
        .overrun_o (o_overrun)
    );
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_q <= S_IDLE;
            pix_q   <= '0;
            line_q  <= '0;
            pad_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= beat;
            if (beat) begin
                data_q <= xfer ? s_data : '0;
                pix_q  <= pix_d;
            end
            case (state_q)
                S_IDLE: if (i_start) begin
                    state_q <= S_PRIME;
                    line_q  <= '0;
                    pad_q   <= '0;
                end
                S_PRIME, S_LINE: if (xfer && last_pix) begin
                    line_q <= line_q + 1'b1;
                    if (state_q == S_LINE || line_q == LW'(PRIME_LINES - 1)) state_q <= S_WAIT;
                end
                S_WAIT: if (pending) state_q <= line_q < LW'(NUM_LINES) ? S_LINE : S_PAD;
                S_PAD: if (last_pix) begin
                    pad_q   <= pad_d;
                    state_q <= pad_d < PDW'(PAD_LINES) ? S_WAIT_PAD : S_DONE;
                end
                S_WAIT_PAD: if (pending) state_q <= S_PAD;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_line_feeder.sv
// tb_pixel_line_feeder: scoreboard bench for pixel_line_feeder with a core interrupt model
module tb_pixel_line_feeder;
    localparam int LW = 8, NL = 6, PL = 4, PD = 2, DW = 8;
    localparam int IMG = LW * NL, TOT = LW * (NL + PD);
    logic axi_clk = 0, axi_reset, i_start, s_valid, s_ready, i_intr;
    logic [DW-1:0] s_data, o_data;
    logic o_data_valid, o_busy, o_done, o_overrun;
    logic model_intr, tb_intr;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_v;
    int checks = 0, errors = 0;
    int src, out_cnt, done_cnt, cyc, cd, prev_out, intr_from;
    int beat_cyc[TOT];
    bit hs, rand_valid;
    assign i_intr = model_intr | tb_intr;
    always #5 axi_clk = ~axi_clk;

    pixel_line_feeder #(.LINE_WIDTH(LW), .NUM_LINES(NL), .PRIME_LINES(PL), .PAD_LINES(PD), .DATA_W(DW)) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset), .i_start(i_start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .i_intr(i_intr), .o_data_valid(o_data_valid), .o_data(o_data),
        .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun)
    );

    task automatic tick();
        @(negedge axi_clk);
        cyc++;
        hs = 0;
        if (axi_reset) begin
            exp_q.delete();
            out_cnt = 0; done_cnt = 0; src = 0; prev_out = 0; cd = 0;
        end else begin
            if (o_data_valid) begin
                checks++;
                if (out_cnt < IMG && exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat%0d: o_data_valid=1 with no preceding handshake", out_cnt);
                end else begin
                    exp_v = out_cnt < IMG ? exp_q.pop_front() : '0;
                    if (o_data !== exp_v) begin
                        errors++;
                        $display("FAIL beat%0d data: got %0h expected %0h", out_cnt, o_data, exp_v);
                    end
                end
                if (out_cnt < TOT) beat_cyc[out_cnt] = cyc;
                out_cnt++;
            end
            if (o_done) done_cnt++;
            hs = s_valid && s_ready;
            if (hs) exp_q.push_back(s_data);
        end
        @(posedge axi_clk);
        #1;
        if (hs) src++;
        s_data = DW'(src);
        s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_cnt != prev_out) begin
            prev_out = out_cnt;
            if (out_cnt % LW == 0 && out_cnt >= intr_from && out_cnt < TOT) cd = 5;
        end
        model_intr = 0;
        if (cd > 0) begin
            cd--;
            model_intr = cd == 0;
        end
    endtask

    task automatic do_reset();
        axi_reset = 1; tb_intr = 0; i_start = 0;
        tick(); tick();
        axi_reset = 0;
    endtask

    task automatic start_frame();
        i_start = 1;
        tick();
        i_start = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000 && done_cnt == 0; i++) tick();
        repeat (10) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (o_data_valid !== 0) begin errors++; $display("FAIL reset o_data_valid: got %b expected 0", o_data_valid); end
        if (o_data !== 0) begin errors++; $display("FAIL reset o_data: got %0h expected 0", o_data); end
        if (o_busy !== 0) begin errors++; $display("FAIL reset o_busy: got %b expected 0", o_busy); end
        if (o_done !== 0) begin errors++; $display("FAIL reset o_done: got %b expected 0", o_done); end
        if (o_overrun !== 0) begin errors++; $display("FAIL reset o_overrun: got %b expected 0", o_overrun); end
        if (s_ready !== 0) begin errors++; $display("FAIL reset s_ready: got %b expected 0", s_ready); end
    endtask

    task automatic test_frame();
        do_reset(); rand_valid = 0; intr_from = PL * LW;
        start_frame();
        checks++;
        if (o_busy !== 1) begin errors++; $display("FAIL frame busy: got %b expected 1", o_busy); end
        wait_done();
        checks += 8;
        if (done_cnt != 1) begin errors++; $display("FAIL frame done pulses: got %0d expected 1", done_cnt); end
        if (out_cnt != TOT) begin errors++; $display("FAIL frame beats: got %0d expected %0d", out_cnt, TOT); end
        if (src != IMG) begin errors++; $display("FAIL frame source consumed: got %0d expected %0d", src, IMG); end
        if (o_overrun !== 0) begin errors++; $display("FAIL frame overrun: got %b expected 0", o_overrun); end
        if (o_busy !== 0) begin errors++; $display("FAIL frame busy after done: got %b expected 0", o_busy); end
        if (beat_cyc[PL*LW-1] - beat_cyc[0] != PL*LW-1) begin errors++; $display("FAIL frame prime span: got %0d expected %0d", beat_cyc[PL*LW-1] - beat_cyc[0], PL*LW-1); end
        if (beat_cyc[IMG-1] - beat_cyc[IMG-LW] != LW-1) begin errors++; $display("FAIL frame line burst span: got %0d expected %0d", beat_cyc[IMG-1] - beat_cyc[IMG-LW], LW-1); end
        if (beat_cyc[TOT-1] - beat_cyc[TOT-LW] != LW-1) begin errors++; $display("FAIL frame pad burst span: got %0d expected %0d", beat_cyc[TOT-1] - beat_cyc[TOT-LW], LW-1); end
    endtask

    task automatic test_random_valid();
        do_reset(); rand_valid = 1; intr_from = PL * LW;
        start_frame();
        wait_done();
        rand_valid = 0;
        checks += 4;
        if (done_cnt != 1) begin errors++; $display("FAIL random done pulses: got %0d expected 1", done_cnt); end
        if (out_cnt != TOT) begin errors++; $display("FAIL random beats: got %0d expected %0d", out_cnt, TOT); end
        if (src != IMG) begin errors++; $display("FAIL random source consumed: got %0d expected %0d", src, IMG); end
        if (o_overrun !== 0) begin errors++; $display("FAIL random overrun: got %b expected 0", o_overrun); end
    endtask

    task automatic test_prime_intr();
        do_reset(); intr_from = (PL + 1) * LW;
        start_frame();
        for (int i = 0; i < 300 && src < PL * LW - 2; i++) tick();
        tb_intr = 1; tick(); tb_intr = 0;
        wait_done();
        checks += 5;
        if (beat_cyc[PL*LW] - beat_cyc[PL*LW-1] != 2) begin errors++; $display("FAIL prime_intr wait gap: got %0d expected 2", beat_cyc[PL*LW] - beat_cyc[PL*LW-1]); end
        if (beat_cyc[(PL+1)*LW] - beat_cyc[(PL+1)*LW-1] <= 5) begin errors++; $display("FAIL prime_intr pending not cleared: gap %0d expected > 5", beat_cyc[(PL+1)*LW] - beat_cyc[(PL+1)*LW-1]); end
        if (done_cnt != 1) begin errors++; $display("FAIL prime_intr done pulses: got %0d expected 1", done_cnt); end
        if (out_cnt != TOT) begin errors++; $display("FAIL prime_intr beats: got %0d expected %0d", out_cnt, TOT); end
        if (o_overrun !== 0) begin errors++; $display("FAIL prime_intr overrun: got %b expected 0", o_overrun); end
    endtask

    task automatic test_overrun();
        do_reset(); intr_from = PL * LW;
        start_frame();
        for (int i = 0; i < 300 && src < 8; i++) tick();
        repeat (3) begin
            tb_intr = 1; tick(); tb_intr = 0; tick(); tick();
        end
        checks++;
        if (o_overrun !== 1) begin errors++; $display("FAIL overrun set: got %b expected 1", o_overrun); end
        wait_done();
        checks += 3;
        if (o_overrun !== 1) begin errors++; $display("FAIL overrun sticky after done: got %b expected 1", o_overrun); end
        if (done_cnt != 1) begin errors++; $display("FAIL overrun done pulses: got %0d expected 1", done_cnt); end
        if (out_cnt != TOT) begin errors++; $display("FAIL overrun beats: got %0d expected %0d", out_cnt, TOT); end
        axi_reset = 1; tick(); axi_reset = 0;
        checks++;
        if (o_overrun !== 0) begin errors++; $display("FAIL overrun cleared by reset: got %b expected 0", o_overrun); end
    endtask

    task automatic test_reset_mid_line();
        do_reset(); intr_from = PL * LW;
        start_frame();
        for (int i = 0; i < 300 && src < PL * LW + 3; i++) tick();
        axi_reset = 1; tick();
        checks += 6;
        if (o_data_valid !== 0) begin errors++; $display("FAIL midreset o_data_valid: got %b expected 0", o_data_valid); end
        if (o_data !== 0) begin errors++; $display("FAIL midreset o_data: got %0h expected 0", o_data); end
        if (o_busy !== 0) begin errors++; $display("FAIL midreset o_busy: got %b expected 0", o_busy); end
        if (o_done !== 0) begin errors++; $display("FAIL midreset o_done: got %b expected 0", o_done); end
        if (o_overrun !== 0) begin errors++; $display("FAIL midreset o_overrun: got %b expected 0", o_overrun); end
        if (s_ready !== 0) begin errors++; $display("FAIL midreset s_ready: got %b expected 0", s_ready); end
        tick(); axi_reset = 0;
        start_frame();
        wait_done();
        checks += 3;
        if (done_cnt != 1) begin errors++; $display("FAIL midreset replay done pulses: got %0d expected 1", done_cnt); end
        if (out_cnt != TOT) begin errors++; $display("FAIL midreset replay beats: got %0d expected %0d", out_cnt, TOT); end
        if (src != IMG) begin errors++; $display("FAIL midreset replay source consumed: got %0d expected %0d", src, IMG); end
    endtask

    task automatic test_start_ignored_held_intr();
        do_reset(); intr_from = (PL + 1) * LW;
        start_frame();
        for (int i = 0; i < 300 && src < 10; i++) tick();
        i_start = 1; tick(); i_start = 0;
        for (int i = 0; i < 300 && out_cnt < PL * LW; i++) tick();
        tick(); tick();
        tb_intr = 1; repeat (4) tick(); tb_intr = 0;
        wait_done();
        checks += 5;
        if (beat_cyc[(PL+1)*LW] - beat_cyc[(PL+1)*LW-1] <= 5) begin errors++; $display("FAIL held_intr counted more than once: gap %0d expected > 5", beat_cyc[(PL+1)*LW] - beat_cyc[(PL+1)*LW-1]); end
        if (o_overrun !== 0) begin errors++; $display("FAIL held_intr overrun: got %b expected 0", o_overrun); end
        if (done_cnt != 1) begin errors++; $display("FAIL start_ignored done pulses: got %0d expected 1", done_cnt); end
        if (out_cnt != TOT) begin errors++; $display("FAIL start_ignored beats: got %0d expected %0d", out_cnt, TOT); end
        if (o_busy !== 0) begin errors++; $display("FAIL start_ignored busy after done: got %b expected 0", o_busy); end
    endtask

    initial begin
        axi_reset = 1; i_start = 0; s_valid = 0; s_data = 0; tb_intr = 0; model_intr = 0;
        rand_valid = 0; intr_from = PL * LW; src = 0; out_cnt = 0; done_cnt = 0; cyc = 0; cd = 0; prev_out = 0;
        test_reset();
        test_frame();
        test_random_valid();
        test_prime_intr();
        test_overrun();
        test_reset_mid_line();
        test_start_ignored_held_intr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
